// File: rtl/axil_uart_ctrl_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite UART controller.
package axil_uart_ctrl_pkg;

  localparam logic [1:0] ADDR_RX   = 2'd0;
  localparam logic [1:0] ADDR_TX   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_RX_EN_BIT    = 0;
  localparam int CTRL_INTR_EN_BIT  = 4;
  localparam int STAT_RX_AVAIL_BIT = 0;
  localparam int STAT_RX_EN_BIT    = 1;
  localparam int STAT_TX_FULL_BIT  = 3;
  localparam int STAT_INTR_EN_BIT  = 4;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

endpackage

// File: rtl/axil_uart_irq.sv
// Interrupt pulse generator: fires once when RX data arrives or TX space frees up.
module axil_uart_irq (
  input  logic clk,
  input  logic rst,
  input  logic intr_enable,
  input  logic empty,
  input  logic full,
  output logic interrupt
);

  logic empty_q;
  logic full_q;

  // Previous samples start low so no spurious edge is seen right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      empty_q   <= 1'b0;
      full_q    <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      empty_q   <= empty;
      full_q    <= full;
      interrupt <= intr_enable & ((empty_q & ~empty) | (full_q & ~full));
    end
  end

endmodule

// File: rtl/axil_uart_ctrl.sv
// AXI4-Lite register front end for a UART core: RX/TX/STAT/CTRL map,
// FIFO push/pop sequencing, receiver enable and interrupt generation.
module axil_uart_ctrl #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_DATA_BITS        = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_DATA_BITS-1:0]          RX_data,
  input  logic                            Empty,
  output logic                            rd_uart_en,
  input  logic                            Full,
  output logic [C_DATA_BITS-1:0]          TX_data,
  output logic                            wr_uart_en,
  output logic                            Enable_rx,
  output logic                            Interrupt
);
  import axil_uart_ctrl_pkg::*;

  wr_state_e                     wr_state;
  rd_state_e                     rd_state;
  logic                          aw_hs, w_hs, ar_hs, wr_exec;
  logic [1:0]                    aw_idx_q, wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wr_data;
  logic                          wstrb0_q, wr_strb0;
  logic                          rx_enable, intr_enable;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_next;
  logic [1:0]                    rd_resp_next;
  logic                          rd_pop;
  logic                          unused_bits;

  assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
  assign Enable_rx = rx_enable;

  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1],
                         wr_data[C_S_AXI_DATA_WIDTH-1:C_DATA_BITS]};

  // A channel handshaking this cycle is used live; the other comes from its latch.
  always_comb begin
    wr_idx   = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
    wr_data  = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb0 = w_hs ? S_AXI_WSTRB[0] : wstrb0_q;
    case (wr_state)
      W_IDLE:      wr_exec = aw_hs & w_hs;
      W_HAVE_ADDR: wr_exec = w_hs;
      W_HAVE_DATA: wr_exec = aw_hs;
      default:     wr_exec = 1'b0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state      <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb0_q      <= 1'b0;
      wr_uart_en    <= 1'b0;
      TX_data       <= '0;
      rx_enable     <= 1'b0;
      intr_enable   <= 1'b0;
    end else begin
      wr_uart_en <= 1'b0;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q  <= S_AXI_WDATA;
        wstrb0_q <= S_AXI_WSTRB[0];
      end
      if (wr_exec) begin
        wr_state      <= W_RESP;
        S_AXI_AWREADY <= 1'b0;
        S_AXI_WREADY  <= 1'b0;
        S_AXI_BVALID  <= 1'b1;
        S_AXI_BRESP   <= RESP_OKAY;
        // A full TX FIFO rejects the write outright, whatever the strobes say.
        case (wr_idx)
          ADDR_TX: begin
            if (Full) begin
              S_AXI_BRESP <= RESP_SLVERR;
            end else if (wr_strb0) begin
              wr_uart_en <= 1'b1;
              TX_data    <= wr_data[C_DATA_BITS-1:0];
            end
          end
          ADDR_CTRL: begin
            if (wr_strb0) begin
              rx_enable   <= wr_data[CTRL_RX_EN_BIT];
              intr_enable <= wr_data[CTRL_INTR_EN_BIT];
            end
          end
          default: ;
        endcase
      end else begin
        case (wr_state)
          W_IDLE: begin
            if (aw_hs) begin
              wr_state      <= W_HAVE_ADDR;
              S_AXI_AWREADY <= 1'b0;
              S_AXI_WREADY  <= 1'b1;
            end else if (w_hs) begin
              wr_state      <= W_HAVE_DATA;
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY  <= 1'b0;
            end else begin
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY  <= 1'b1;
            end
          end
          W_RESP: begin
            if (S_AXI_BREADY) begin
              wr_state      <= W_IDLE;
              S_AXI_BVALID  <= 1'b0;
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read data is sampled at the AR handshake, so a same-cycle CTRL write is not yet visible.
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_OKAY;
    rd_pop       = 1'b0;
    case (S_AXI_ARADDR[3:2])
      ADDR_RX: begin
        if (!Empty) begin
          rd_data_next[C_DATA_BITS-1:0] = RX_data;
          rd_pop = 1'b1;
        end else begin
          rd_resp_next = RESP_SLVERR;
        end
      end
      ADDR_STAT: begin
        rd_data_next[STAT_RX_AVAIL_BIT] = ~Empty;
        rd_data_next[STAT_RX_EN_BIT]    = rx_enable;
        rd_data_next[STAT_TX_FULL_BIT]  = Full;
        rd_data_next[STAT_INTR_EN_BIT]  = intr_enable;
      end
      ADDR_CTRL: begin
        rd_data_next[CTRL_RX_EN_BIT]   = rx_enable;
        rd_data_next[CTRL_INTR_EN_BIT] = intr_enable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rd_state      <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      rd_uart_en    <= 1'b0;
    end else begin
      rd_uart_en <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state      <= R_RESP;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_data_next;
            S_AXI_RRESP   <= rd_resp_next;
            rd_uart_en    <= rd_pop;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rd_state      <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  axil_uart_irq u_irq (
    .clk         (S_AXI_ACLK),
    .rst         (S_AXI_ARESET),
    .intr_enable (intr_enable),
    .empty       (Empty),
    .full        (Full),
    .interrupt   (Interrupt)
  );

endmodule

// File: tb/tb_axil_uart_ctrl.sv
// Randomised bench for axil_uart_ctrl: a register/FIFO model predicts every bus
// response, FIFO push/pop and interrupt pulse.
module tb_axil_uart_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DB = 8;

  logic          S_AXI_ACLK = 1'b0;
  logic          S_AXI_ARESET = 1'b0;
  logic [AW-1:0] S_AXI_AWADDR;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [DB-1:0] RX_data;
  logic          Empty;
  logic          rd_uart_en;
  logic          Full;
  logic [DB-1:0] TX_data;
  logic          wr_uart_en;
  logic          Enable_rx;
  logic          Interrupt;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  axil_uart_ctrl #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_DATA_BITS(DB)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .RX_data(RX_data), .Empty(Empty), .rd_uart_en(rd_uart_en),
    .Full(Full), .TX_data(TX_data), .wr_uart_en(wr_uart_en),
    .Enable_rx(Enable_rx), .Interrupt(Interrupt)
  );

  // UART RX FIFO stand-in: the bench appends at the tail, the DUT pops the head.
  logic [7:0] rxMem [256];
  logic [7:0] rxHead = '0;
  logic [7:0] rxTail = '0;
  assign Empty   = (rxHead == rxTail);
  assign RX_data = rxMem[rxHead];
  always @(posedge S_AXI_ACLK) if (rd_uart_en) rxHead <= rxHead + 8'd1;

  int         txCount = 0;
  int         rdCount = 0;
  int         irqCount = 0;
  logic [7:0] txLast = '0;
  always @(negedge S_AXI_ACLK) begin
    if (wr_uart_en) begin
      txCount++;
      txLast = TX_data;
    end
    if (rd_uart_en) rdCount++;
    if (Interrupt) irqCount++;
  end

  int totalChecks = 0;
  int badChecks = 0;
  bit mRx = 1'b0;
  bit mIntr = 1'b0;
  int expTx = 0;
  int expRd = 0;
  int expIrq = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic doReset();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_ARESET = 1'b1;
    #1;
    checkOutput("rst_bvalid", S_AXI_BVALID, 0);
    checkOutput("rst_rvalid", S_AXI_RVALID, 0);
    step();
    step();
    checkOutput("rst_awready", S_AXI_AWREADY, 0);
    checkOutput("rst_wready", S_AXI_WREADY, 0);
    checkOutput("rst_arready", S_AXI_ARREADY, 0);
    checkOutput("rst_enable_rx", Enable_rx, 0);
    checkOutput("rst_irq", Interrupt, 0);
    checkOutput("rst_pulses", {wr_uart_en, rd_uart_en}, 0);
    S_AXI_ARESET = 1'b0;
    mRx = 1'b0;
    mIntr = 1'b0;
    step();
    checkOutput("rel_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    step();
  endtask

  task automatic setFifo(input bit pushByte, input logic [7:0] b, input logic newFull);
    bit wasEmpty;
    bit fullFell;
    wasEmpty = (rxHead == rxTail);
    fullFell = Full && !newFull;
    if (pushByte) begin
      rxMem[rxTail] = b;
      rxTail = rxTail + 8'd1;
    end
    Full = newFull;
    if (mIntr && ((wasEmpty && pushByte) || fullFell)) expIrq++;
    repeat (3) step();
    checkOutput("irq_count", irqCount, expIrq);
  endtask

  // One bus episode: an optional write and/or read, each channel launched at its own cycle.
  task automatic applyStimulus(input bit doWr, input logic [3:0] wAddr, input logic [31:0] wData,
                               input logic [3:0] wStrb, input int awStart, input int wStart,
                               input int bDelay, input bit doRd, input logic [3:0] rAddr,
                               input int arStart, input int rDelay, output logic [31:0] rdOut);
    logic [1:0]  expB, gotB, expRr, gotRr;
    logic [31:0] expR, gotR;
    logic [7:0]  pushByte;
    bit          expPush, expPop, emptyNow;
    bit          awDone, wDone, bDone, arDone, rDone, bSeen, rSeen;
    bit          hsAw, hsW, hsB, hsAr, hsR;
    int          bFirst, rFirst, c;

    if (doWr && doRd && wAddr[3:2] == 2'd3 && rAddr[3:2] >= 2'd2) begin
      awStart = 0; wStart = 0; arStart = 0;
    end
    emptyNow = (rxHead == rxTail);
    expB = 2'b00; expPush = 0; pushByte = wData[7:0];
    expR = 0; expRr = 2'b00; expPop = 0;
    if (doRd) begin
      case (rAddr[3:2])
        2'd0: if (!emptyNow) begin expR = {24'd0, rxMem[rxHead]}; expPop = 1; end
              else expRr = 2'b10;
        2'd2: expR = {27'd0, mIntr, Full, 1'b0, mRx, !emptyNow};
        2'd3: expR = {27'd0, mIntr, 3'b000, mRx};
        default: expR = 0;
      endcase
    end
    if (doWr) begin
      if (wAddr[3:2] == 2'd1) begin
        if (Full) expB = 2'b10;
        else if (wStrb[0]) expPush = 1;
      end else if (wAddr[3:2] == 2'd3 && wStrb[0]) begin
        mRx = wData[0];
        mIntr = wData[4];
      end
    end

    awDone = !doWr; wDone = !doWr; bDone = !doWr; arDone = !doRd; rDone = !doRd;
    bSeen = 0; rSeen = 0; bFirst = 0; rFirst = 0; gotB = 0; gotR = 0; gotRr = 0;
    c = 0;
    while (!(awDone && wDone && bDone && arDone && rDone) && c < 100) begin
      if (!awDone && c == awStart) begin S_AXI_AWVALID = 1; S_AXI_AWADDR = wAddr; end
      if (!wDone && c == wStart) begin S_AXI_WVALID = 1; S_AXI_WDATA = wData; S_AXI_WSTRB = wStrb; end
      if (!arDone && c == arStart) begin S_AXI_ARVALID = 1; S_AXI_ARADDR = rAddr; end
      if (!bDone) begin
        if (bSeen) begin
          checkOutput("bvalid_hold", S_AXI_BVALID, 1);
          checkOutput("bresp_hold", S_AXI_BRESP, gotB);
        end else if (S_AXI_BVALID) begin
          bSeen = 1; bFirst = c; gotB = S_AXI_BRESP;
        end
        if (bSeen && c - bFirst >= bDelay) S_AXI_BREADY = 1;
      end
      if (!rDone) begin
        if (rSeen) begin
          checkOutput("rvalid_hold", S_AXI_RVALID, 1);
          checkOutput("rdata_hold", S_AXI_RDATA, gotR);
        end else if (S_AXI_RVALID) begin
          rSeen = 1; rFirst = c; gotR = S_AXI_RDATA; gotRr = S_AXI_RRESP;
        end
        if (rSeen && c - rFirst >= rDelay) S_AXI_RREADY = 1;
      end
      hsAw = S_AXI_AWVALID && S_AXI_AWREADY;
      hsW  = S_AXI_WVALID && S_AXI_WREADY;
      hsAr = S_AXI_ARVALID && S_AXI_ARREADY;
      hsB  = S_AXI_BVALID && S_AXI_BREADY;
      hsR  = S_AXI_RVALID && S_AXI_RREADY;
      step();
      if (hsAw) begin S_AXI_AWVALID = 0; awDone = 1; end
      if (hsW)  begin S_AXI_WVALID = 0; wDone = 1; end
      if (hsAr) begin S_AXI_ARVALID = 0; arDone = 1; end
      if (hsB)  begin S_AXI_BREADY = 0; bDone = 1; end
      if (hsR)  begin S_AXI_RREADY = 0; rDone = 1; end
      c++;
    end
    checkOutput("txn_done", {awDone, wDone, bDone, arDone, rDone}, 5'b11111);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    step();
    step();

    if (doWr) begin
      checkOutput("bresp", gotB, expB);
      checkOutput("bvalid_drop", S_AXI_BVALID, 0);
      if (expPush) begin
        expTx++;
        checkOutput("tx_data", txLast, pushByte);
      end
    end
    if (doRd) begin
      checkOutput("rdata", gotR, expR);
      checkOutput("rresp", gotRr, expRr);
      checkOutput("rvalid_drop", S_AXI_RVALID, 0);
      if (expPop) expRd++;
    end
    checkOutput("tx_count", txCount, expTx);
    checkOutput("rd_count", rdCount, expRd);
    checkOutput("enable_rx", Enable_rx, mRx);
    checkOutput("irq_quiet", irqCount, expIrq);
    rdOut = gotR;
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  a;
    int          op;
    for (int i = 0; i < 256; i++) rxMem[i] = '0;
    S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0; Full = 0;
    #2;
    doReset();

    applyStimulus(1, 4'h4, 32'h000000A5, 4'hF, 0, 0, 0, 0, 4'h0, 0, 0, rd);
    setFifo(0, 8'h00, 1);
    applyStimulus(1, 4'h4, 32'h000000A5, 4'hF, 0, 0, 0, 0, 4'h0, 0, 0, rd);
    setFifo(0, 8'h00, 0);
    applyStimulus(1, 4'hC, 32'h00000011, 4'hF, 2, 0, 3, 0, 4'h0, 0, 0, rd);

    // Abort a write after only its address was accepted.
    S_AXI_AWADDR = 4'h4;
    S_AXI_AWVALID = 1;
    step();
    S_AXI_AWVALID = 0;
    step();
    doReset();
    checkOutput("abort_bvalid", S_AXI_BVALID, 0);
    repeat (3) step();
    checkOutput("abort_no_push", txCount, expTx);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'hC, 0, 0, rd);
    checkOutput("ctrl_after_reset", rd, 32'h0);

    applyStimulus(1, 4'hC, 32'h00000010, 4'hF, 0, 0, 0, 0, 4'h0, 0, 0, rd);
    setFifo(1, 8'h55, 0);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 1, rd);
    checkOutput("rx_55", rd, 32'h55);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 0, rd);
    applyStimulus(1, 4'hC, 32'h00000011, 4'hF, 0, 0, 0, 0, 4'h0, 0, 0, rd);
    setFifo(1, 8'h66, 1);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'h8, 0, 0, rd);
    checkOutput("stat_1b", rd, 32'h1B);
    setFifo(0, 8'h00, 0);
    applyStimulus(1, 4'h4, 32'h0000003C, 4'hF, 0, 0, 0, 1, 4'h8, 0, 5, rd);
    applyStimulus(1, 4'hC, 32'h00000000, 4'h1, 0, 0, 0, 1, 4'hC, 0, 2, rd);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      a = 4'($urandom);
      if (op == 0) begin
        setFifo(($urandom_range(0, 1) == 1) && (8'(rxTail - rxHead) < 8'd4),
                8'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(op != 2, a, $urandom, 4'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      op != 1, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 4), rd);
      end
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/axil_uart_ctrl.md
Name: axil_uart_ctrl

Overview:
- AXI4-Lite slave controller that sequences the UART core's RX/TX FIFO handshakes (rd_uart_en/RX_data/Empty, wr_uart_en/TX_data/Full).
- Exposes a four-register map (RX, TX, STAT, CTRL) to the bus.
- Drives the UART's Enable_rx and generates the Interrupt line.
- Sits between the AXI interconnect and the UART instance, in the same clock domain.

Parameters:
- C_S_AXI_ADDR_WIDTH, 4, AXI address width; decode uses bits [3:2].
- C_S_AXI_DATA_WIDTH, 32, AXI data width.
- C_DATA_BITS, 8, UART word width; must be ≤ C_S_AXI_DATA_WIDTH.

Ports:
- S_AXI_ACLK  in  1  single system clock
- S_AXI_ARESET  in  1  reset, asynchronous, active-high
- S_AXI_AWADDR  in  ADDR_W  write address
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
- S_AXI_WDATA  in  DATA_W  write data
- S_AXI_WSTRB  in  DATA_W/8  write strobes
- S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARADDR  in  ADDR_W  read address
- S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
- S_AXI_RDATA  out  DATA_W  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID out 1; S_AXI_RREADY in 1
- RX_data  in  C_DATA_BITS  head of UART RX FIFO; valid while Empty=0
- Empty  in  1  RX FIFO empty
- rd_uart_en  out  1  one-cycle pop of RX FIFO
- Full  in  1  TX FIFO full
- TX_data  out  C_DATA_BITS  word to push
- wr_uart_en  out  1  one-cycle push to TX FIFO
- Enable_rx  out  1  UART receiver enable (CTRL[0])
- Interrupt  out  1  one-cycle interrupt pulse

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; CTRL=0; both FSMs in IDLE.
  - AWREADY/WREADY/ARREADY also 0 during reset and go high the first cycle after release.
- Register map, ADDR[3:2]; ADDR[1:0] ignored:
  - 0x0 RX: read only.
  - 0x4 TX: write only.
  - 0x8 STAT: read only. bit0 = !Empty, bit1 = CTRL[0], bit3 = Full, bit4 = CTRL[4]; other bits 0.
  - 0xC CTRL: read/write. bit0 = rx_enable, bit4 = intr_enable; other bits read 0.
- Write FSM:
  - States: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - AWREADY is high in W_IDLE and W_HAVE_DATA. WREADY is high in W_IDLE and W_HAVE_ADDR.
  - AW and W may arrive in the same cycle or in either order; each is latched on its handshake.
  - When both are held, the write executes in that cycle and the FSM enters W_RESP with BVALID=1 on the next cycle.
  - BVALID and BRESP hold until BREADY, then return to W_IDLE.
- Write effects:
  - TX, WSTRB[0]=1, Full=0: TX_data=WDATA[7:0] and wr_uart_en=1 for exactly one cycle (the cycle after execute). BRESP=OKAY (00).
  - TX, Full=1 at execute: no push, BRESP=SLVERR (10).
  - TX, WSTRB[0]=0: no push, OKAY.
  - CTRL: bit0 updated if WSTRB[0]; bit4 updated if WSTRB[0]. OKAY.
  - RX/STAT: ignored, OKAY.
- Read FSM:
  - States: R_IDLE, R_RESP. ARREADY=1 only in R_IDLE.
  - An AR handshake in cycle N captures RDATA/RRESP; RVALID=1 from N+1 and held stable until RREADY.
- Read effects:
  - RX with Empty=0: RDATA = zero-extended RX_data, OKAY, rd_uart_en=1 for exactly one cycle (N+1).
  - RX with Empty=1: RDATA=0, SLVERR, no pop.
  - TX: RDATA=0, OKAY.
  - STAT/CTRL: sampled at cycle N.
- Read and write channels are independent; both may complete in the same cycle.
- A CTRL write and a STAT/CTRL read executing in the same cycle: the read returns the pre-write value.
- Interrupt, registered, only when CTRL[4]=1: pulses one cycle on a 1→0 transition of Empty (RX data arrived) or a 1→0 transition of Full (TX space freed). Both edges in the same cycle produce a single pulse.
- Reset mid-transaction aborts it: no pending pop/push is issued after reset and BVALID/RVALID drop immediately.

Decomposition:
- Package axil_uart_ctrl_pkg:
  - Register offsets: ADDR_RX=2'd0, ADDR_TX=2'd1, ADDR_STAT=2'd2, ADDR_CTRL=2'd3.
  - AXI response codes: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - CTRL/STAT bit indices.
  - Write-FSM and read-FSM state enums.
- Sub-module axil_uart_irq: edge detector + enable gating producing the Interrupt pulse.

Test Plan:
- Reset: assert S_AXI_ARESET mid-write with AW accepted → BVALID=0, wr_uart_en never pulses, CTRL reads 0x0 after release.
- TX write: AW=0x4 and W=0x000000A5 (WSTRB=0xF) in the same cycle, Full=0 → wr_uart_en pulses exactly one cycle with TX_data=0xA5, BRESP=00. Repeat with Full=1 → no pulse, BRESP=10.
- Out-of-order write: W (0x11) two cycles before AW=0xC → CTRL=0x11, Enable_rx=1, BVALID held until BREADY asserted 3 cycles later.
- RX read: UART receives 0x55 (Empty falls), CTRL=0x10 → Interrupt one-cycle pulse; AR=0x0 → RDATA=0x55, RRESP=00, exactly one rd_uart_en pulse. A second AR=0x0 with Empty=1 → RDATA=0, RRESP=10.
- STAT read with Empty=0, Full=1, CTRL=0x11 → RDATA=0x1B.
- Concurrent traffic: read 0x8 and write 0x4 handshaked in the same cycle with RREADY held low for 5 cycles → RDATA stable throughout; both responses delivered with correct values.
